// File: rtl/reg_dst_addr_mux.sv
// Destination-register address select (rt / rd / link) with a registered output.
// The output register doubles as the write-address slice of the next pipeline stage.
module reg_dst_addr_mux #(
  parameter int                ADDR_W     = 5,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  input  logic [1:0]        RegDst,
  output logic [ADDR_W-1:0] addr_w,
  output logic              addr_w_nz
);

  // Code 2'b11 is reserved and means "no register write", so it maps to r0.
  function automatic logic [ADDR_W-1:0] sel_addr(
    input logic [1:0]        reg_dst,
    input logic [ADDR_W-1:0] a_rt,
    input logic [ADDR_W-1:0] a_rd,
    input logic [ADDR_W-1:0] a_link
  );
    logic [ADDR_W-1:0] r;
    r = '0;
    case (reg_dst)
      2'b00:   r = a_rt;
      2'b01:   r = a_rd;
      2'b10:   r = a_link;
      default: r = '0;
    endcase
    return r;
  endfunction

  localparam logic RESET_NZ = (RESET_ADDR != '0);

  logic [ADDR_W-1:0] sel_p0;
  logic [ADDR_W-1:0] addr_w_p1;
  logic              addr_w_nz_p1;

  always_comb begin
    sel_p0 = sel_addr(RegDst, addr1, addr2, addr3);
  end

  // Stage p0 -> p1: flush beats stall, so a bubble can be inserted while held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_w_p1    <= RESET_ADDR;
      addr_w_nz_p1 <= RESET_NZ;
    end else if (clr) begin
      addr_w_p1    <= RESET_ADDR;
      addr_w_nz_p1 <= RESET_NZ;
    end else if (en) begin
      addr_w_p1    <= sel_p0;
      addr_w_nz_p1 <= (sel_p0 != '0);
    end
  end

  assign addr_w    = addr_w_p1;
  assign addr_w_nz = addr_w_nz_p1;

endmodule

// File: tb/tb_reg_dst_addr_mux.sv
// Directed bench for reg_dst_addr_mux: reset, select sweep, stall, flush,
// zero destination and unselected-input isolation.
module tb_reg_dst_addr_mux;

  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              en;
  logic              clr;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [ADDR_W-1:0] addr3;
  logic [1:0]        RegDst;
  logic [ADDR_W-1:0] addr_w;
  logic              addr_w_nz;

  int n_checks = 0;
  int n_fail   = 0;

  reg_dst_addr_mux #(.ADDR_W(ADDR_W), .RESET_ADDR('0)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .addr1     (addr1),
    .addr2     (addr2),
    .addr3     (addr3),
    .RegDst    (RegDst),
    .addr_w    (addr_w),
    .addr_w_nz (addr_w_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got t=%0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle just after it; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    en     = 1'b1;
    clr    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr1  = ADDR_W'($urandom);
      addr2  = ADDR_W'($urandom);
      addr3  = ADDR_W'($urandom);
      RegDst = 2'($urandom);
      tick();
      n_checks++;
      if (addr_w !== 5'd0 || addr_w_nz !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got addr_w=%0d nz=%b, required 0/0", i, addr_w, addr_w_nz);
      end
    end
    reset = 1'b0;
    addr2 = 5'd12; RegDst = 2'b01;
    tick();
    n_checks++;
    if (addr_w !== 5'd12 || addr_w_nz !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_load: got addr_w=%0d nz=%b, required 12/1", addr_w, addr_w_nz);
    end
    // Assert reset mid-cycle: output must clear with no clock edge.
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (addr_w !== 5'd0 || addr_w_nz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got addr_w=%0d nz=%b, required 0/0", addr_w, addr_w_nz);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_select_sweep();
    logic [ADDR_W-1:0] exp_a [4];
    logic              exp_nz[4];
    exp_a  = '{5'd5, 5'd9, 5'd31, 5'd0};
    exp_nz = '{1'b1, 1'b1, 1'b1, 1'b0};
    addr1 = 5'd5; addr2 = 5'd9; addr3 = 5'd31; en = 1'b1; clr = 1'b0;
    for (int s = 0; s < 4; s++) begin
      RegDst = 2'(s);
      tick();
      n_checks++;
      if (addr_w !== exp_a[s] || addr_w_nz !== exp_nz[s]) begin
        n_fail++;
        $display("FAIL sweep_regdst%0d: got addr_w=%0d nz=%b, required %0d/%b",
                 s, addr_w, addr_w_nz, exp_a[s], exp_nz[s]);
      end
    end
  endtask

  task automatic test_stall();
    RegDst = 2'b01; addr2 = 5'd9; en = 1'b1; clr = 1'b0;
    tick();
    n_checks++;
    if (addr_w !== 5'd9) begin
      n_fail++;
      $display("FAIL stall_load: got addr_w=%0d, required 9", addr_w);
    end
    en = 1'b0; RegDst = 2'b10; addr3 = 5'd31;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (addr_w !== 5'd9 || addr_w_nz !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got addr_w=%0d nz=%b, required 9/1", i, addr_w, addr_w_nz);
      end
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (addr_w !== 5'd31 || addr_w_nz !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_resume: got addr_w=%0d nz=%b, required 31/1", addr_w, addr_w_nz);
    end
  endtask

  task automatic test_flush();
    // addr_w is 31 from the stall test.
    clr = 1'b1; en = 1'b0;
    tick();
    n_checks++;
    if (addr_w !== 5'd0 || addr_w_nz !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_during_stall: got addr_w=%0d nz=%b, required 0/0", addr_w, addr_w_nz);
    end
    addr2 = 5'd9; addr3 = 5'd31; RegDst = 2'b10; en = 1'b1;
    tick();
    RegDst = 2'b01; clr = 1'b1; en = 1'b1;
    tick();
    n_checks++;
    if (addr_w !== 5'd0 || addr_w_nz !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_over_enable: got addr_w=%0d nz=%b, required 0/0", addr_w, addr_w_nz);
    end
    clr = 1'b0;
  endtask

  task automatic test_zero_dest();
    addr1 = 5'd22; RegDst = 2'b00; en = 1'b1; clr = 1'b0;
    tick();
    addr1 = 5'd0;
    tick();
    n_checks++;
    if (addr_w !== 5'd0 || addr_w_nz !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_dest: got addr_w=%0d nz=%b, required 0/0", addr_w, addr_w_nz);
    end
    addr1 = 5'd17;
    tick();
    n_checks++;
    if (addr_w !== 5'd17 || addr_w_nz !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_dest_then17: got addr_w=%0d nz=%b, required 17/1", addr_w, addr_w_nz);
    end
  endtask

  task automatic test_isolation();
    logic [ADDR_W-1:0] fixed_v [3];
    fixed_v = '{5'd7, 5'd3, 5'd26};
    en = 1'b1; clr = 1'b0;
    for (int s = 0; s < 4; s++) begin
      RegDst = 2'(s);
      for (int c = 0; c < 5; c++) begin
        addr1 = (s == 0) ? fixed_v[0] : ADDR_W'($urandom);
        addr2 = (s == 1) ? fixed_v[1] : ADDR_W'($urandom);
        addr3 = (s == 2) ? fixed_v[2] : ADDR_W'($urandom);
        tick();
        n_checks++;
        if (s == 3) begin
          if (addr_w !== 5'd0 || addr_w_nz !== 1'b0) begin
            n_fail++;
            $display("FAIL isolation_sel3[%0d]: got addr_w=%0d nz=%b, required 0/0", c, addr_w, addr_w_nz);
          end
        end else if (addr_w !== fixed_v[s] || addr_w_nz !== 1'b1) begin
          n_fail++;
          $display("FAIL isolation_sel%0d[%0d]: got addr_w=%0d nz=%b, required %0d/1",
                   s, c, addr_w, addr_w_nz, fixed_v[s]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a1_v [4];
    logic [1:0]        rd_v [4];
    logic [ADDR_W-1:0] exp_v[4];
    a1_v  = '{5'd1, 5'd2, 5'd4, 5'd8};
    rd_v  = '{2'b00, 2'b01, 2'b10, 2'b00};
    exp_v = '{5'd1, 5'd11, 5'd21, 5'd8};
    addr2 = 5'd11; addr3 = 5'd21; en = 1'b1; clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr1 = a1_v[i]; RegDst = rd_v[i];
      // Mid-cycle glitch on inputs before restoring them must not matter.
      #2 addr1 = 5'd30;
      #1 addr1 = a1_v[i];
      tick();
      n_checks++;
      if (addr_w !== exp_v[i] || addr_w_nz !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got addr_w=%0d nz=%b, required %0d/1",
                 i, addr_w, addr_w_nz, exp_v[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0;
    addr1 = '0; addr2 = '0; addr3 = '0; RegDst = 2'b00;
    test_reset();
    test_select_sweep();
    test_stall();
    test_flush();
    test_zero_dest();
    test_isolation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
